// File: rtl/osc_phase_gen_pkg.sv
// Shared defaults and state encoding for the tracker oscillator phase generator.
package tracker_osc_pkg;

  localparam int unsigned DEF_PHASE_W = 24;
  localparam int unsigned DEF_INC_W   = 16;
  localparam int unsigned DEF_ADDR_W  = 9;
  localparam int unsigned RATE_W      = 8;

  typedef enum logic {
    OSC_IDLE = 1'b0,
    OSC_RUN  = 1'b1
  } osc_state_e;

endpackage

// File: rtl/osc_phase_gen_inc_slew.sv
// Portamento step: moves cur toward target by rate, clamping exactly at target.
module inc_slew
  import tracker_osc_pkg::*;
#(
  parameter int unsigned INC_W = DEF_INC_W
) (
  input  logic [INC_W-1:0]  cur,
  input  logic [INC_W-1:0]  target,
  input  logic [RATE_W-1:0] rate,
  input  logic              step_en,
  output logic [INC_W-1:0]  next_cur
);

  logic [INC_W-1:0] rate_ext;
  logic [INC_W-1:0] gap_up;
  logic [INC_W-1:0] gap_dn;

  always_comb begin
    rate_ext = INC_W'(rate);
    gap_up   = target - cur;
    gap_dn   = cur - target;
    next_cur = cur;
    if (step_en) begin
      // A zero rate means no slide: jump straight to the target.
      if (rate == '0) begin
        next_cur = target;
      end else if (cur < target) begin
        next_cur = (gap_up <= rate_ext) ? target : cur + rate_ext;
      end else if (cur > target) begin
        next_cur = (gap_dn <= rate_ext) ? target : cur - rate_ext;
      end
    end
  end

endmodule

// File: rtl/osc_phase_gen.sv
// Gated phase accumulator with note handshake, retrigger and increment slide,
// producing registered waveform LUT addresses on each audio sample tick.
module osc_phase_gen
  import tracker_osc_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned INC_W   = DEF_INC_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              gate,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [INC_W-1:0]  note_inc,
  input  logic              note_retrig,
  input  logic [7:0]        slide_rate,
  output logic [ADDR_W-1:0] addr_full,
  output logic              addr_valid,
  output logic              wrap
);

  osc_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [INC_W-1:0]   cur_inc_q, cur_inc_d;
  logic [INC_W-1:0]   target_inc_q, target_inc_d;
  logic [INC_W-1:0]   lat_inc_q, lat_inc_d;
  logic               lat_retrig_q, lat_retrig_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  addr_full_q, addr_full_d;
  logic               addr_valid_q, addr_valid_d;
  logic               wrap_q, wrap_d;

  logic               handshake;
  logic               apply_note;
  logic               step;
  logic               slew_en;
  logic [INC_W-1:0]   eff_target;
  logic [INC_W-1:0]   next_cur;
  logic [PHASE_W-1:0] base_phase;
  logic [PHASE_W:0]   sum_full;

  // A note accepted on a tick is only latched here; it becomes visible at the
  // next tick because apply_note looks at the registered pending flag.
  assign handshake  = note_valid && !pending_q;
  assign apply_note = sample_tick && pending_q;
  assign step       = sample_tick && (state_q == OSC_RUN);
  assign eff_target = apply_note ? lat_inc_q : target_inc_q;
  assign slew_en    = step || (apply_note && (slide_rate == '0));

  inc_slew #(
    .INC_W (INC_W)
  ) u_inc_slew (
    .cur      (cur_inc_q),
    .target   (eff_target),
    .rate     (slide_rate),
    .step_en  (slew_en),
    .next_cur (next_cur)
  );

  always_comb begin
    base_phase = (apply_note && lat_retrig_q) ? '0 : phase_q;
    sum_full   = {1'b0, base_phase} + (PHASE_W+1)'(next_cur);
  end

  always_comb begin
    state_d      = gate ? OSC_RUN : OSC_IDLE;
    phase_d      = phase_q;
    cur_inc_d    = next_cur;
    target_inc_d = eff_target;
    lat_inc_d    = lat_inc_q;
    lat_retrig_d = lat_retrig_q;
    pending_d    = pending_q;
    addr_full_d  = addr_full_q;
    addr_valid_d = 1'b0;
    wrap_d       = 1'b0;

    if (handshake) begin
      lat_inc_d    = note_inc;
      lat_retrig_d = note_retrig;
      pending_d    = 1'b1;
    end
    if (apply_note) begin
      pending_d = 1'b0;
    end

    if (state_q == OSC_IDLE) begin
      phase_d     = '0;
      addr_full_d = '0;
    end else if (step) begin
      phase_d      = sum_full[PHASE_W-1:0];
      addr_full_d  = sum_full[PHASE_W-1 -: ADDR_W];
      addr_valid_d = 1'b1;
      wrap_d       = sum_full[PHASE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OSC_IDLE;
      phase_q      <= '0;
      cur_inc_q    <= '0;
      target_inc_q <= '0;
      lat_inc_q    <= '0;
      lat_retrig_q <= 1'b0;
      pending_q    <= 1'b0;
      addr_full_q  <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cur_inc_q    <= cur_inc_d;
      target_inc_q <= target_inc_d;
      lat_inc_q    <= lat_inc_d;
      lat_retrig_q <= lat_retrig_d;
      pending_q    <= pending_d;
      addr_full_q  <= addr_full_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign note_ready = ~pending_q;
  assign addr_full  = addr_full_q;
  assign addr_valid = addr_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_osc_phase_gen.sv
// Directed bench for osc_phase_gen with a 16-bit phase so addr_full = phase[15:7].
module tb_osc_phase_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        gate;
  logic        note_valid;
  logic        note_ready;
  logic [15:0] note_inc;
  logic        note_retrig;
  logic [7:0]  slide_rate;
  logic [8:0]  addr_full;
  logic        addr_valid;
  logic        wrap;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  osc_phase_gen #(
    .PHASE_W (16),
    .INC_W   (16),
    .ADDR_W  (9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .gate        (gate),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_inc    (note_inc),
    .note_retrig (note_retrig),
    .slide_rate  (slide_rate),
    .addr_full   (addr_full),
    .addr_valid  (addr_valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        tick;
    logic        gt;
    logic        nv;
    logic [15:0] inc;
    logic        rt;
    logic [8:0]  ea;
    logic        ev;
    logic        ew;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic tick, input logic gt,
                              input logic nv, input logic [15:0] inc, input logic rt,
                              input logic [8:0] ea, input logic ev, input logic ew,
                              input logic er);
    vec_t v;
    v.rst = rst; v.tick = tick; v.gt = gt; v.nv = nv; v.inc = inc; v.rt = rt;
    v.ea = ea; v.ev = ev; v.ew = ew; v.er = er;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic tick, input logic gt, input logic nv,
                       input logic [15:0] inc, input logic rt, input logic [7:0] rate);
    reset       = rst;
    sample_tick = tick;
    gate        = gt;
    note_valid  = nv;
    note_inc    = inc;
    note_retrig = rt;
    slide_rate  = rate;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] ea, input logic ev,
                       input logic ew, input logic er);
    n_checks++;
    if (addr_full !== ea || addr_valid !== ev || wrap !== ew || note_ready !== er) begin
      n_fail++;
      $display("FAIL %s: got addr=%h valid=%b wrap=%b ready=%b, want addr=%h valid=%b wrap=%b ready=%b",
               name, addr_full, addr_valid, wrap, note_ready, ea, ev, ew, er);
    end
  endtask

  logic [8:0] up_exp [8] = '{9'h003, 9'h007, 9'h00C, 9'h012, 9'h019, 9'h021, 9'h029, 9'h031};
  logic [8:0] dn_exp [7] = '{9'h006, 9'h00B, 9'h00F, 9'h011, 9'h011, 9'h011, 9'h011};

  initial begin
    reset = 1'b1; sample_tick = 1'b0; gate = 1'b0; note_valid = 1'b0;
    note_inc = '0; note_retrig = 1'b0; slide_rate = '0;

    //            rst tk gt nv inc       rt   addr    v  w  rdy
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 9'h000, 0, 0, 1)); // reset
    tbl.push_back(mk(0, 0, 1, 1, 16'h8000, 1, 9'h000, 0, 0, 0)); // note, enter RUN
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h100, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h100, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h100, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h000, 1, 1, 1)); // wrap
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h100, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 16'h4000, 0, 9'h000, 1, 1, 0)); // handshake on tick
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h080, 1, 0, 1)); // new inc now
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 16'h2000, 1, 9'h100, 0, 0, 0)); // first note
    tbl.push_back(mk(0, 0, 1, 1, 16'h1000, 0, 9'h100, 0, 0, 0)); // refused
    tbl.push_back(mk(0, 1, 1, 1, 16'h1000, 0, 9'h040, 1, 0, 1)); // refused, first applied
    tbl.push_back(mk(0, 0, 1, 1, 16'h1000, 0, 9'h040, 0, 0, 0)); // second accepted
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h060, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 9'h060, 0, 0, 1)); // gate falls
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 9'h000, 0, 0, 1)); // idle ignores tick
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1)); // tick on IDLE->RUN
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h020, 1, 0, 1)); // restart from 0
    tbl.push_back(mk(0, 0, 1, 1, 16'h8000, 0, 9'h020, 0, 0, 0)); // pending
    tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1)); // reset wins
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 9'h000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h000, 1, 0, 1)); // note was lost
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 9'h000, 1, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].tick, tbl[i].gt, tbl[i].nv, tbl[i].inc, tbl[i].rt, 8'h00);
      check($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ev, tbl[i].ew, tbl[i].er);
    end

    // Upward slide 0x0100 -> 0x0400 at 0x80 per tick, retriggered base.
    drive(1, 0, 0, 0, 16'h0000, 0, 8'h00);
    check("slide_reset", 9'h000, 0, 0, 1);
    drive(0, 0, 1, 1, 16'h0100, 1, 8'h00);
    drive(0, 1, 1, 0, 16'h0000, 0, 8'h00);
    check("slide_base", 9'h002, 1, 0, 1);
    drive(0, 0, 1, 1, 16'h0400, 1, 8'h80);
    check("slide_hs", 9'h002, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 0, 16'h0000, 0, 8'h80);
      check($sformatf("slide_up%0d", i), up_exp[i], 1, 0, 1);
      drive(0, 0, 1, 0, 16'h0000, 0, 8'h80);
    end

    // Downward slide 0x0400 -> 0 at 0xC0, must clamp at zero.
    drive(0, 0, 1, 1, 16'h0000, 1, 8'hC0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 1, 0, 16'h0000, 0, 8'hC0);
      check($sformatf("slide_dn%0d", i), dn_exp[i], 1, 0, 1);
      drive(0, 0, 1, 0, 16'h0000, 0, 8'hC0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_phase_gen.md
OSC_PHASE_GEN -- requirements
Module: osc_phase_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-002 SHALL have parameter INC_W, default 16, tuning-word width (INC_W <= PHASE_W).
REQ-003 SHALL have parameter ADDR_W, default 9, waveform LUT address width, taken from the phase MSBs.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_tick  input  1  one-cycle strobe at the audio sample rate.
REQ-007 SHALL have port gate  input  1  level; 1 = oscillator running, 0 = idle.
REQ-008 SHALL have port note_valid  input  1  new target tuning word offered.
REQ-009 SHALL have port note_ready  output  1  block can accept a note.
REQ-010 SHALL have port note_inc  input  INC_W  target phase increment per sample, unsigned.
REQ-011 SHALL have port note_retrig  input  1  qualified by the note handshake; 1 = zero the phase when the note is applied.
REQ-012 SHALL have port slide_rate  input  8  unsigned increment step per sample; 0 = no slide.
REQ-013 SHALL have port addr_full  output  ADDR_W  waveform LUT address.
REQ-014 SHALL have port addr_valid  output  1  one-cycle strobe; addr_full updated this cycle.
REQ-015 SHALL have port wrap  output  1  one-cycle strobe; accumulator overflowed on this step.

Function
REQ-016 SHALL implement FSM states IDLE and RUN: IDLE->RUN on gate=1; RUN->IDLE on gate=0, evaluated every cycle.
REQ-017 SHALL, in IDLE, hold phase at 0, addr_full at 0, and emit no addr_valid or wrap strobes.
REQ-018 SHALL, in RUN on sample_tick, update phase <= (phase + cur_inc) mod 2^PHASE_W, cur_inc zero-extended to PHASE_W.
REQ-019 SHALL register addr_full = phase_next[PHASE_W-1 -: ADDR_W] with addr_valid=1 in the cycle after sample_tick, giving a latency of 1 cycle.
REQ-020 SHALL assert wrap together with addr_valid when the addition produces a carry out of bit PHASE_W-1.
REQ-021 SHALL drive note_ready = ~pending; a handshake completes when note_valid && note_ready, latching note_inc and note_retrig and setting pending.
REQ-022 SHALL apply a pending note on the next sample_tick (in either state): target_inc <= latched inc, pending cleared, note_ready high again on the following cycle.
REQ-023 SHALL, when the applied note has retrig=1, use phase 0 as the base for that tick's addition, so that the emitted phase = cur_inc.
REQ-024 SHALL, when slide_rate=0, set cur_inc <= target_inc at the application tick, with the step itself using the new cur_inc.
REQ-025 SHALL, when slide_rate>0, move cur_inc toward target_inc by slide_rate on each RUN sample_tick, clamping exactly to target_inc with no overshoot or underflow.
REQ-026 SHALL, when a handshake and sample_tick coincide, latch the note and apply it on the next sample_tick rather than the current one.
REQ-027 SHALL, when gate falls mid-slide, freeze cur_inc; returning to RUN SHALL restart from phase 0 with the frozen cur_inc.
REQ-028 SHALL treat a sample_tick arriving in the same cycle as the IDLE->RUN transition as not yet running, so no step occurs.

Reset
REQ-029 SHALL, on reset=1, set state IDLE, phase 0, cur_inc 0, target_inc 0, pending 0, addr_full 0, addr_valid 0, wrap 0, note_ready 1.
REQ-030 SHALL give reset priority over every input, including a simultaneous handshake or sample_tick, and SHALL discard a pending note.

Structure
REQ-031 SHALL take the PHASE_W/INC_W/ADDR_W defaults and the FSM state enum (OSC_IDLE, OSC_RUN) from shared package tracker_osc_pkg.
REQ-032 SHALL place the slide/clamp arithmetic in sub-module inc_slew (inputs cur, target, rate, step_en; output next_cur).
REQ-033 SHALL keep all outputs registered, with no combinational path from inputs to outputs except note_ready.

Verification
REQ-034 SHALL cover: reset, gate=1, note_inc=0x8000 retrig=1, ticks every 4 cycles -> addr_full sequence 0x100, 0x000(wrap=1), 0x100, each strobe 1 cycle after its tick.
REQ-035 SHALL cover: cur_inc=0x0100, note_inc=0x0400, slide_rate=0x80 -> cur_inc 0x0180, 0x0200 ... 0x0400, then held at 0x0400, no overshoot.
REQ-036 SHALL cover: a second note_valid while pending -> note_ready=0 until the next tick, and the second note is accepted only after it.
REQ-037 SHALL cover: a handshake in the same cycle as sample_tick -> the new inc takes effect at the following tick, not the current one.
REQ-038 SHALL cover: gate low mid-run -> no strobes and addr_full=0; gate high -> first strobe addr_full = cur_inc[15:15-ADDR_W+9...] derived from phase 0 + cur_inc.
REQ-039 SHALL cover: reset asserted with pending=1 and addr_valid due -> all outputs at reset values on the next cycle, and the note is lost.
